// File: rtl/adrf_spi_pkg.sv
// adrf_spi_pkg: shared constants and FSM state type for the ADRF SPI responder.
// Frame layout (MSB first): [23:17] address, [16] R/W (1 = read), [15:0] data.
package adrf_spi_pkg;

  localparam int FRAME_W    = 24;
  localparam int ADDR_MSB   = 23;
  localparam int RW_BIT     = 16;
  localparam int DATA_MSB   = 15;
  localparam int HDR_BITS   = 8;
  localparam int CNT_W      = 5;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/adrf_spi_regfile.sv
// adrf_spi_regfile: mirror of the ADRF register space. One synchronous write
// port, a combinational side read port and, when ADRF_SPI_RESPONDER_READBACK_EN
// is defined, a second combinational read port feeding the readback shifter.
module adrf_spi_regfile
  import adrf_spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              GCLK,
  input  logic              reset,
`ifdef ADRF_SPI_RESPONDER_READBACK_EN
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
`endif
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] cfg_raddr,
  output logic [DATA_W-1:0] cfg_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Every entry clears on reset; completed write frames land here.
  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign cfg_rdata = mem[cfg_raddr];

`ifdef ADRF_SPI_RESPONDER_READBACK_EN
  assign rb_data = mem[rb_addr];
`endif

endmodule

// File: rtl/adrf_spi_responder.sv
// adrf_spi_responder: receiving end of the 24-bit ADRF register-write stream.
// Decodes frames into a mirror register file, reports writes and aborts.
// Optional feature macro: ADRF_SPI_RESPONDER_READBACK_EN (serial readback on
// ADRF_SPI_SDO); when undefined ADRF_SPI_SDO is tied low.
module adrf_spi_responder
  import adrf_spi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              GCLK,
  input  logic              reset,
  input  logic              ADRF_CS,
  input  logic              ADRF_SPI_IN,
  output logic              ADRF_SPI_SDO,
  output logic              WR_VALID,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              FRAME_ERR,
  output logic [7:0]        FRAME_COUNT,
  input  logic [ADDR_W-1:0] CFG_RADDR,
  output logic [DATA_W-1:0] CFG_RDATA
);

  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(FRAME_W);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shift_reg;
  logic               commit;

  logic               sampling;
  logic               abort;
  logic               last_bit;
  logic [ADDR_W-1:0]  frame_addr;
  logic               frame_rw;
  logic [DATA_W-1:0]  frame_data;
  logic               mirror_we;

  assign sampling   = !ADRF_CS && (state != DONE);
  assign abort      = ADRF_CS && ((state == HDR) || (state == DATA));
  assign last_bit   = !ADRF_CS && (state == DATA) && (bit_cnt == CNT_LAST);
  assign frame_addr = shift_reg[ADDR_MSB -: ADDR_W];
  assign frame_rw   = shift_reg[RW_BIT];
  assign frame_data = shift_reg[DATA_MSB -: DATA_W];
  assign mirror_we  = commit && !frame_rw;

  // State register.
  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame sequencing: header bits, data bits, then hold until CS releases.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!ADRF_CS) state_nxt = HDR;
      HDR: begin
        if (ADRF_CS)                       state_nxt = IDLE;
        else if (bit_cnt == CNT_HDR_LAST)  state_nxt = DATA;
      end
      DATA: begin
        if (ADRF_CS)                       state_nxt = IDLE;
        else if (bit_cnt == CNT_LAST)      state_nxt = DONE;
      end
      DONE: if (ADRF_CS) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter and input shifter; bits after the 24th are not sampled.
  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (abort || ((state == DONE) && ADRF_CS)) bit_cnt <= '0;
      else if (sampling && (bit_cnt != CNT_MAX))  bit_cnt <= bit_cnt + 1'b1;
      if (sampling) shift_reg <= {shift_reg[FRAME_W-2:0], ADRF_SPI_IN};
    end
  end

  // Frame completion one edge after the last bit, plus abort reporting.
  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      commit      <= 1'b0;
      WR_VALID    <= 1'b0;
      FRAME_ERR   <= 1'b0;
      WR_ADDR     <= '0;
      WR_DATA     <= '0;
      FRAME_COUNT <= '0;
    end else begin
      commit    <= last_bit;
      WR_VALID  <= mirror_we;
      FRAME_ERR <= abort;
      if (commit) FRAME_COUNT <= FRAME_COUNT + 8'd1;
      if (mirror_we) begin
        WR_ADDR <= frame_addr;
        WR_DATA <= frame_data;
      end
    end
  end

`ifdef ADRF_SPI_RESPONDER_READBACK_EN
  localparam int LEFT_W = $clog2(DATA_W);

  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] rb_shift;
  logic [LEFT_W-1:0] rb_left;
  logic              rb_load;

  // The address is complete in the low shifter bits when the R/W bit arrives.
  assign rb_addr = shift_reg[ADDR_W-1:0];
  assign rb_load = !ADRF_CS && (state == HDR) && (bit_cnt == CNT_HDR_LAST) && ADRF_SPI_IN;

  // Readback shifter: MSB on the R/W edge, then one bit per data edge.
  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      ADRF_SPI_SDO <= 1'b0;
      rb_shift     <= '0;
      rb_left      <= '0;
    end else if (rb_load) begin
      ADRF_SPI_SDO <= rb_data[DATA_W-1];
      rb_shift     <= {rb_data[DATA_W-2:0], 1'b0};
      rb_left      <= LEFT_W'(DATA_W - 1);
    end else if (!ADRF_CS && (state == DATA) && (rb_left != '0)) begin
      ADRF_SPI_SDO <= rb_shift[DATA_W-1];
      rb_shift     <= {rb_shift[DATA_W-2:0], 1'b0};
      rb_left      <= rb_left - 1'b1;
    end else begin
      ADRF_SPI_SDO <= 1'b0;
      rb_left      <= '0;
    end
  end
`else
  assign ADRF_SPI_SDO = 1'b0;
`endif

  adrf_spi_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regfile (
    .GCLK     (GCLK),
    .reset    (reset),
`ifdef ADRF_SPI_RESPONDER_READBACK_EN
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
`endif
    .we       (mirror_we),
    .waddr    (frame_addr),
    .wdata    (frame_data),
    .cfg_raddr(CFG_RADDR),
    .cfg_rdata(CFG_RDATA)
  );

endmodule

// File: tb/tb_adrf_spi_responder.sv
// tb_adrf_spi_responder: directed frames with hand-computed expectations.
module tb_adrf_spi_responder;

  logic        GCLK = 1'b0;
  logic        reset = 1'b1;
  logic        ADRF_CS = 1'b1;
  logic        ADRF_SPI_IN = 1'b0;
  logic        ADRF_SPI_SDO;
  logic        WR_VALID;
  logic [6:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic        FRAME_ERR;
  logic [7:0]  FRAME_COUNT;
  logic [6:0]  CFG_RADDR = 7'h00;
  logic [15:0] CFG_RDATA;

  int checks = 0;
  int passes = 0;
  int wr_pulses = 0;
  int err_pulses = 0;

  adrf_spi_responder dut (
    .GCLK        (GCLK),
    .reset       (reset),
    .ADRF_CS     (ADRF_CS),
    .ADRF_SPI_IN (ADRF_SPI_IN),
    .ADRF_SPI_SDO(ADRF_SPI_SDO),
    .WR_VALID    (WR_VALID),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .FRAME_ERR   (FRAME_ERR),
    .FRAME_COUNT (FRAME_COUNT),
    .CFG_RADDR   (CFG_RADDR),
    .CFG_RDATA   (CFG_RDATA)
  );

  always #5 GCLK = ~GCLK;

  // Pulse counters sampled mid-cycle.
  always @(negedge GCLK) begin
    if (WR_VALID === 1'b1) wr_pulses++;
    if (FRAME_ERR === 1'b1) err_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else passes++;
  endtask

  // Drive one bit period at the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic cs, input logic sdi);
    @(negedge GCLK);
    ADRF_CS = cs;
    ADRF_SPI_IN = sdi;
    @(posedge GCLK);
    #1;
  endtask

  task automatic sendBits(input logic [23:0] frame, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, frame[23-i]);
  endtask

  task automatic doReset();
    @(negedge GCLK);
    reset = 1'b1;
    ADRF_CS = 1'b1;
    @(negedge GCLK);
    @(negedge GCLK);
    reset = 1'b0;
  endtask

  logic [23:0] rd_frame;
  logic [15:0] rb;
  int          wr_before;
  int          err_before;

  initial begin
    doReset();
    checkOutput("rst_sdo", ADRF_SPI_SDO, 0);
    checkOutput("rst_wr_valid", WR_VALID, 0);
    checkOutput("rst_frame_err", FRAME_ERR, 0);
    checkOutput("rst_wr_addr", WR_ADDR, 0);
    checkOutput("rst_wr_data", WR_DATA, 0);
    checkOutput("rst_count", FRAME_COUNT, 0);

    // Write frame 0x02F67F: addr 0x01, data 0xF67F.
    CFG_RADDR = 7'h01;
    sendBits(24'h02F67F, 24);
    checkOutput("wr_latency", WR_VALID, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("wr_valid", WR_VALID, 1);
    checkOutput("wr_addr", WR_ADDR, 32'h01);
    checkOutput("wr_data", WR_DATA, 32'hF67F);
    checkOutput("wr_count", FRAME_COUNT, 1);
    checkOutput("wr_mirror", CFG_RDATA, 32'hF67F);
    applyStimulus(1'b1, 1'b0);
    checkOutput("wr_valid_pulse", WR_VALID, 0);

    // Read frame 0x030000 of address 0x01.
    wr_before = wr_pulses;
    rd_frame = 24'h030000;
    rb = '0;
    for (int i = 23; i >= 0; i--) begin
      applyStimulus(1'b0, rd_frame[i]);
      if (i >= 1 && i <= 16) rb[i-1] = ADRF_SPI_SDO;
    end
    checkOutput("sdo_after_d0", ADRF_SPI_SDO, 0);
`ifdef ADRF_SPI_RESPONDER_READBACK_EN
    checkOutput("readback", rb, 32'hF67F);
`else
    checkOutput("readback_off", rb, 0);
`endif
    applyStimulus(1'b1, 1'b0);
    checkOutput("rd_count", FRAME_COUNT, 2);
    checkOutput("rd_no_valid", WR_VALID, 0);
    checkOutput("rd_wr_data_kept", WR_DATA, 32'hF67F);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rd_no_pulse", wr_pulses - wr_before, 0);

    // Abort after 10 bits of 0x66141E (addr 0x33).
    err_before = err_pulses;
    CFG_RADDR = 7'h33;
    sendBits(24'h66141E, 10);
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_err", FRAME_ERR, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_err_pulse", FRAME_ERR, 0);
    checkOutput("abort_mirror", CFG_RDATA, 0);
    checkOutput("abort_count", FRAME_COUNT, 2);

    // Single low edge is also an abort.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort1_err", FRAME_ERR, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_err_total", err_pulses - err_before, 2);
    checkOutput("abort1_count", FRAME_COUNT, 2);

    // 26 bits low, first 24 = 0x9814B4 (addr 0x4C, data 0x14B4).
    wr_before = wr_pulses;
    CFG_RADDR = 7'h4C;
    sendBits(24'h9814B4, 24);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("long_mirror", CFG_RDATA, 32'h14B4);
    checkOutput("long_addr", WR_ADDR, 32'h4C);
    checkOutput("long_data", WR_DATA, 32'h14B4);
    checkOutput("long_count", FRAME_COUNT, 3);
    checkOutput("long_pulses", wr_pulses - wr_before, 1);

    // Asynchronous reset at bit 12 of 0x442A03 (addr 0x22, data 0x2A03).
    sendBits(24'h442A03, 12);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mrst_count", FRAME_COUNT, 0);
    checkOutput("mrst_wr_addr", WR_ADDR, 0);
    checkOutput("mrst_wr_data", WR_DATA, 0);
    checkOutput("mrst_mirror_4c", CFG_RDATA, 0);
    CFG_RADDR = 7'h22;
    #1;
    checkOutput("mrst_mirror_22", CFG_RDATA, 0);
    @(negedge GCLK);
    ADRF_CS = 1'b1;
    @(negedge GCLK);
    reset = 1'b0;
    sendBits(24'h442A03, 24);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_valid", WR_VALID, 1);
    checkOutput("post_rst_addr", WR_ADDR, 32'h22);
    checkOutput("post_rst_data", WR_DATA, 32'h2A03);
    checkOutput("post_rst_mirror", CFG_RDATA, 32'h2A03);
    checkOutput("post_rst_count", FRAME_COUNT, 1);

    // 256 back-to-back write frames wrap FRAME_COUNT.
    doReset();
    wr_before = wr_pulses;
    for (int i = 0; i < 256; i++) begin
      logic [23:0] f;
      f = {i[6:0], 1'b0, 16'(i)};
      sendBits(f, 24);
      applyStimulus(1'b1, 1'b0);
      if (i == 127) checkOutput("wrap_half", FRAME_COUNT, 128);
    end
    applyStimulus(1'b1, 1'b0);
    CFG_RADDR = 7'h7F;
    #1;
    checkOutput("wrap_count", FRAME_COUNT, 0);
    checkOutput("wrap_pulses", wr_pulses - wr_before, 256);
    checkOutput("wrap_last_addr", WR_ADDR, 32'h7F);
    checkOutput("wrap_last_data", WR_DATA, 32'h00FF);
    checkOutput("wrap_mirror", CFG_RDATA, 32'h00FF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
